keypad_col_scanner: RTL and testbench

Parametrised keypad matrix scanner. It drives NUM_COLS columns one at a time in a rotating one-hot pattern and samples NUM_ROWS row lines through a 2-flop synchroniser. When a key is detected it stops on that column, debounces the press, reports a single encoded key event, then debounces the release. It sits between the keypad pins and the digit-entry/adder logic and runs on the 1 kHz slow clock.

---
 rtl/keypad_col_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_col_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_col_scanner.sv
// Keypad matrix scanner: rotates a one-hot column drive, synchronises the row lines,
// debounces press and release, and emits one encoded key event per press.
module keypad_col_scanner #(
    parameter int NUM_COLS        = 4,
    parameter int NUM_ROWS        = 4,
    parameter int DWELL_CYCLES    = 2,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter bit COL_ACTIVE_LOW  = 1'b0,
    parameter bit ROW_ACTIVE_LOW  = 1'b0,
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                slow_clk,
    input  logic                rst_n,
    input  logic                scan_en,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] col_drive,
    output logic [CW-1:0]       column_index,
    output logic                key_valid,
    output logic [CW+RW-1:0]    key_code,
    output logic                key_held,
    output logic                multi_key
);

    localparam int DWW = $clog2(DWELL_CYCLES);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [NUM_ROWS-1:0] ROW_IDLE = ROW_ACTIVE_LOW ? {NUM_ROWS{1'b1}} : '0;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD} state_t;

    state_t              state_q, state_n;
    logic [NUM_ROWS-1:0] sync_meta, sync_q, rs;
    logic [NUM_ROWS-1:0] pat_q, pat_n;
    logic [DWW-1:0]      dwell_q, dwell_n;
    logic [DBW-1:0]      deb_q, deb_n, rel_q, rel_n;
    logic [CW-1:0]       col_n;
    logic [CW+RW-1:0]    code_n;
    logic                kv_n, held_n, multi_n;

    function automatic logic [NUM_COLS-1:0] drive_of(input logic [CW-1:0] idx);
        logic [NUM_COLS-1:0] oh;
        for (int i = 0; i < NUM_COLS; i++) oh[i] = (idx == CW'(i));
        return COL_ACTIVE_LOW ? ~oh : oh;
    endfunction

    function automatic logic [CW-1:0] next_col(input logic [CW-1:0] idx);
        return (idx == CW'(NUM_COLS - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [RW-1:0] lowest_set(input logic [NUM_ROWS-1:0] v);
        logic [RW-1:0] idx;
        idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) if (v[i]) idx = RW'(i);
        return idx;
    endfunction

    function automatic logic many_set(input logic [NUM_ROWS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_ROWS; i++) if (v[i]) n++;
        return n > 1;
    endfunction

    // The synchroniser runs even while scan_en is low so it never presents stale rows.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= ROW_IDLE;
            sync_q    <= ROW_IDLE;
        end else begin
            sync_meta <= rows;
            sync_q    <= sync_meta;
        end
    end

    assign rs = ROW_ACTIVE_LOW ? ~sync_q : sync_q;

    always_comb begin
        state_n = state_q;
        col_n   = column_index;
        dwell_n = dwell_q;
        deb_n   = deb_q;
        rel_n   = rel_q;
        pat_n   = pat_q;
        kv_n    = 1'b0;
        code_n  = key_code;
        held_n  = key_held;
        multi_n = multi_key;
        if (scan_en) begin
            case (state_q)
                SCAN: begin
                    if (dwell_q == DWW'(DWELL_CYCLES - 1)) begin
                        dwell_n = '0;
                        if (rs == '0) begin
                            col_n = next_col(column_index);
                        end else begin
                            pat_n   = rs;
                            deb_n   = '0;
                            state_n = DEB_PRESS;
                        end
                    end else begin
                        dwell_n = dwell_q + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (rs == pat_q) begin
                        if (deb_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                            kv_n    = 1'b1;
                            code_n  = {column_index, lowest_set(pat_q)};
                            multi_n = many_set(pat_q);
                            held_n  = 1'b1;
                            rel_n   = '0;
                            state_n = HELD;
                        end else begin
                            deb_n = deb_q + 1'b1;
                        end
                    end else begin
                        // Bounce: drop the candidate and move on without reporting.
                        col_n   = next_col(column_index);
                        dwell_n = '0;
                        state_n = SCAN;
                    end
                end
                HELD: begin
                    if (rs == '0) begin
                        if (rel_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                            col_n   = next_col(column_index);
                            dwell_n = '0;
                            rel_n   = '0;
                            held_n  = 1'b0;
                            state_n = SCAN;
                        end else begin
                            rel_n = rel_q + 1'b1;
                        end
                    end else begin
                        rel_n = '0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SCAN;
            column_index <= '0;
            col_drive    <= drive_of('0);
            dwell_q      <= '0;
            deb_q        <= '0;
            rel_q        <= '0;
            pat_q        <= '0;
            key_valid    <= 1'b0;
            key_code     <= '0;
            key_held     <= 1'b0;
            multi_key    <= 1'b0;
        end else begin
            state_q      <= state_n;
            column_index <= col_n;
            col_drive    <= drive_of(col_n);
            dwell_q      <= dwell_n;
            deb_q        <= deb_n;
            rel_q        <= rel_n;
            pat_q        <= pat_n;
            key_valid    <= kv_n;
            key_code     <= code_n;
            key_held     <= held_n;
            multi_key    <= multi_n;
        end
    end

endmodule

// File: tb/tb_keypad_col_scanner.sv
// Directed bench for keypad_col_scanner: default 4x4 instance plus a 3x2 active-low instance.
module tb_keypad_col_scanner;

    logic       slow_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       scan_en  = 1'b1;
    logic [3:0] rows     = 4'b0000;
    logic [3:0] col_drive;
    logic [1:0] column_index;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi_key;

    logic [1:0] rows5 = 2'b11;
    logic [2:0] col_drive5;
    logic [1:0] column_index5;
    logic       key_valid5;
    logic [2:0] key_code5;
    logic       key_held5;
    logic       multi_key5;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    always #5 slow_clk = ~slow_clk;

    keypad_col_scanner u_dut (
        .slow_clk(slow_clk), .rst_n(rst_n), .scan_en(scan_en), .rows(rows),
        .col_drive(col_drive), .column_index(column_index), .key_valid(key_valid),
        .key_code(key_code), .key_held(key_held), .multi_key(multi_key)
    );

    keypad_col_scanner #(
        .NUM_COLS(3), .NUM_ROWS(2), .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b1)
    ) u_dut5 (
        .slow_clk(slow_clk), .rst_n(rst_n), .scan_en(scan_en), .rows(rows5),
        .col_drive(col_drive5), .column_index(column_index5), .key_valid(key_valid5),
        .key_code(key_code5), .key_held(key_held5), .multi_key(multi_key5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge slow_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    // Scoreboard: every key_valid pulse of the default instance must match a queued code.
    always @(negedge slow_clk) begin
        if (rst_n && key_valid) begin
            if (exp_q.size() == 0) check("unexpected_key_valid", 32'd1, 32'd0);
            else check("key_code_at_valid", 32'(key_code), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cols[9];
        int exp_drv[9];
        exp_cols = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        exp_drv  = '{1, 1, 2, 2, 4, 4, 8, 8, 1};

        // 1: free-running scan after reset
        do_reset();
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_held", 32'(key_held), 32'd0);
        check("rst_multi_key", 32'(multi_key), 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) ticks(1);
            check("scan_col_idx", 32'(column_index), 32'(exp_cols[i]));
            check("scan_col_drive", 32'(col_drive), 32'(exp_drv[i]));
            check("scan_key_valid", 32'(key_valid), 32'd0);
        end

        // 2: single key on column 2 (rows set one cycle early to cover the synchroniser)
        do_reset();
        ticks(3);
        rows = 4'b0100;
        exp_q.push_back(4'b1010);
        ticks(5);
        check("t2_pre_valid", 32'(key_valid), 32'd0);
        check("t2_col_frozen", 32'(column_index), 32'd2);
        ticks(1);
        check("t2_valid", 32'(key_valid), 32'd1);
        check("t2_code", 32'(key_code), 32'b1010);
        check("t2_multi", 32'(multi_key), 32'd0);
        check("t2_held", 32'(key_held), 32'd1);
        check("t2_drive", 32'(col_drive), 32'b0100);
        ticks(3);
        check("t2_valid_once", 32'(key_valid), 32'd0);
        check("t2_still_held", 32'(key_held), 32'd1);
        rows = 4'b0000;
        ticks(4);
        check("t2_held_release_deb", 32'(key_held), 32'd1);
        ticks(1);
        check("t2_released", 32'(key_held), 32'd0);
        check("t2_next_col", 32'(column_index), 32'd3);
        check("t2_next_drive", 32'(col_drive), 32'b1000);
        check("t2_code_kept", 32'(key_code), 32'b1010);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: two-cycle bounce on column 1
        do_reset();
        ticks(1);
        rows = 4'b0001;
        ticks(2);
        rows = 4'b0000;
        ticks(2);
        check("t3_col_during_deb", 32'(column_index), 32'd1);
        ticks(1);
        check("t3_abort_col", 32'(column_index), 32'd2);
        check("t3_not_held", 32'(key_held), 32'd0);
        check("t3_code_clear", 32'(key_code), 32'd0);
        ticks(6);

        // 4: two rows on column 0, captured on the second lap
        do_reset();
        ticks(7);
        rows = 4'b0110;
        exp_q.push_back(4'b0001);
        ticks(5);
        check("t4_pre_valid", 32'(key_valid), 32'd0);
        ticks(1);
        check("t4_valid", 32'(key_valid), 32'd1);
        check("t4_code", 32'(key_code), 32'b0001);
        check("t4_multi", 32'(multi_key), 32'd1);
        check("t4_col", 32'(column_index), 32'd0);
        rows = 4'b0000;
        ticks(5);
        check("t4_released", 32'(key_held), 32'd0);
        check("t4_next_col", 32'(column_index), 32'd1);
        check("t4_multi_kept", 32'(multi_key), 32'd1);

        // 5: 3x2 active-low instance
        do_reset();
        check("t5_drive0", 32'(col_drive5), 32'b110);
        check("t5_col0", 32'(column_index5), 32'd0);
        ticks(2);
        check("t5_drive1", 32'(col_drive5), 32'b101);
        ticks(2);
        check("t5_drive2", 32'(col_drive5), 32'b011);
        ticks(2);
        check("t5_drive_wrap", 32'(col_drive5), 32'b110);
        ticks(3);
        rows5 = 2'b01;
        ticks(5);
        check("t5_pre_valid", 32'(key_valid5), 32'd0);
        ticks(1);
        check("t5_valid", 32'(key_valid5), 32'd1);
        check("t5_code", 32'(key_code5), 32'b101);
        check("t5_held", 32'(key_held5), 32'd1);
        check("t5_drive_hold", 32'(col_drive5), 32'b011);
        rows5 = 2'b11;
        ticks(6);

        // 6: freeze during HELD, then async reset during DEB_PRESS
        do_reset();
        ticks(3);
        rows = 4'b0100;
        exp_q.push_back(4'b1010);
        ticks(6);
        check("t6_held", 32'(key_held), 32'd1);
        ticks(1);
        scan_en = 1'b0;
        rows    = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            ticks(1);
            check("t6_frozen_held", 32'(key_held), 32'd1);
            check("t6_frozen_col", 32'(column_index), 32'd2);
            check("t6_frozen_valid", 32'(key_valid), 32'd0);
        end
        scan_en = 1'b1;
        ticks(2);
        check("t6_release_deb", 32'(key_held), 32'd1);
        rows = 4'b1000;
        ticks(1);
        check("t6_released", 32'(key_held), 32'd0);
        check("t6_col3", 32'(column_index), 32'd3);
        ticks(3);
        rst_n = 1'b0;
        #2;
        check("t6_rst_col", 32'(column_index), 32'd0);
        check("t6_rst_drive", 32'(col_drive), 32'b0001);
        check("t6_rst_held", 32'(key_held), 32'd0);
        check("t6_rst_code", 32'(key_code), 32'd0);
        check("t6_rst_valid", 32'(key_valid), 32'd0);
        rows = 4'b0000;
        ticks(2);
        rst_n = 1'b1;
        ticks(12);
        check("t6_no_event", 32'(key_code), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
